// File: rtl/switch_multi_debouncer_if.sv
// Switch bus between the board pins, the debouncer and the tester FSM.
// The change strobe is present only when SWITCH_CHANGE_STROBE_EN is defined.
interface switch_multi_debouncer_if #(
    parameter int P_SWITCH_COUNT = 4
);
    logic [P_SWITCH_COUNT-1:0] ei_switches;
    logic [P_SWITCH_COUNT-1:0] o_switches_debounced;
`ifdef SWITCH_CHANGE_STROBE_EN
    logic                      o_switches_changed;

    modport master (
        output ei_switches,
        input  o_switches_debounced,
        input  o_switches_changed
    );

    modport slave (
        input  ei_switches,
        output o_switches_debounced,
        output o_switches_changed
    );
`else
    modport master (
        output ei_switches,
        input  o_switches_debounced
    );

    modport slave (
        input  ei_switches,
        output o_switches_debounced
    );
`endif
endinterface

// File: rtl/switch_multi_debouncer.sv
// Per-bit 2-flop synchronizer + 4-state debounce FSM with stability counter.
// Optional change strobe enabled by defining SWITCH_CHANGE_STROBE_EN.
module switch_multi_debouncer #(
    parameter int P_SWITCH_COUNT  = 4,
    parameter int P_STABLE_CYCLES = 20000
) (
    input  logic                     i_clk_20mhz,
    input  logic                     i_rst_20mhz,
    switch_multi_debouncer_if.slave  sw
);

    localparam int CNT_W = $clog2(P_STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(P_STABLE_CYCLES - 1);
    // The edge that enters an ARM state is the first stable sample, so the
    // switch-over fires once the counter has seen P_STABLE_CYCLES-2 more.
    localparam logic [CNT_W-1:0] CNT_FIRE = CNT_W'(P_STABLE_CYCLES - 2);

    // Bit 1 of the encoding is the debounced output value.
    localparam logic [1:0] ST_OFF     = 2'b00;
    localparam logic [1:0] ST_ARM_ON  = 2'b01;
    localparam logic [1:0] ST_ON      = 2'b11;
    localparam logic [1:0] ST_ARM_OFF = 2'b10;

    generate
        if (P_STABLE_CYCLES < 2) begin : g_bad_param
            $error("switch_multi_debouncer: P_STABLE_CYCLES must be >= 2");
        end
    endgenerate

    logic [P_SWITCH_COUNT-1:0] deb;

    for (genvar b = 0; b < P_SWITCH_COUNT; b++) begin : g_bit
        logic             sync_p0;
        logic             sync_p1;
        logic [1:0]       state_p2;
        logic [CNT_W-1:0] cnt_p2;

        always_ff @(posedge i_clk_20mhz) begin
            if (i_rst_20mhz) begin
                sync_p0  <= 1'b0;
                sync_p1  <= 1'b0;
                state_p2 <= ST_OFF;
                cnt_p2   <= '0;
            end else begin
                // stage p0/p1: synchronizer
                sync_p0 <= sw.ei_switches[b];
                sync_p1 <= sync_p0;

                // stage p2: debounce FSM
                case (state_p2)
                    ST_OFF: begin
                        if (sync_p1) begin
                            state_p2 <= ST_ARM_ON;
                            cnt_p2   <= '0;
                        end
                    end
                    ST_ARM_ON: begin
                        if (!sync_p1) begin
                            state_p2 <= ST_OFF;
                            cnt_p2   <= '0;
                        end else if (cnt_p2 == CNT_FIRE) begin
                            state_p2 <= ST_ON;
                            cnt_p2   <= '0;
                        end else if (cnt_p2 < CNT_MAX) begin
                            cnt_p2 <= cnt_p2 + CNT_W'(1);
                        end
                    end
                    ST_ON: begin
                        if (!sync_p1) begin
                            state_p2 <= ST_ARM_OFF;
                            cnt_p2   <= '0;
                        end
                    end
                    ST_ARM_OFF: begin
                        if (sync_p1) begin
                            state_p2 <= ST_ON;
                            cnt_p2   <= '0;
                        end else if (cnt_p2 == CNT_FIRE) begin
                            state_p2 <= ST_OFF;
                            cnt_p2   <= '0;
                        end else if (cnt_p2 < CNT_MAX) begin
                            cnt_p2 <= cnt_p2 + CNT_W'(1);
                        end
                    end
                    default: begin
                        state_p2 <= ST_OFF;
                        cnt_p2   <= '0;
                    end
                endcase
            end
        end

        assign deb[b] = state_p2[1];
    end

    assign sw.o_switches_debounced = deb;

`ifdef SWITCH_CHANGE_STROBE_EN
    logic [P_SWITCH_COUNT-1:0] prev_p3;
    logic                      changed_p3;

    // stage p3: change detect against the previous debounced vector
    always_ff @(posedge i_clk_20mhz) begin
        if (i_rst_20mhz) begin
            prev_p3    <= '0;
            changed_p3 <= 1'b0;
        end else begin
            prev_p3    <= deb;
            changed_p3 <= (prev_p3 != deb);
        end
    end

    assign sw.o_switches_changed = changed_p3;
`endif

endmodule
